matmul_sequencer: RTL and testbench
===================================

Name: matmul_sequencer

Overview:
- Sequences an unsigned 8-bit matrix multiply C = A x B over the shared 16-bit-address, 32-bit-data memory bus decoded by the memory controller.
- Matrix A is stored in DM1 (page 4'h0), matrix B in DM2 (page 4'h1), and result matrix C in DM3 (page 4'h2).
- The block issues every read and write and accumulates products internally.
- It is the master on the controller's address/DATA/write_en/Q interface while busy.

Parameters:
- N, 4, matrix dimension; legal range 1..64.
- A_BASE, 12'h000, word offset of A(0,0) within DM1.
- B_BASE, 12'h000, word offset of B(0,0) within DM2.
- C_BASE, 12'h000, word offset of C(0,0) within DM3.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a multiply; sampled only in IDLE.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the last C element has been written.
- mem_address  output  16  {page[3:0], word[11:0]} to the controller address input.
- mem_data  output  32  write data to the controller DATA input.
- mem_write_en  output  1  write strobe to the controller write_en input.
- mem_q  input  32  read data from the controller Q output; valid the cycle after the address is presented.

Behaviour:
- Reset value of all outputs is 0. Reset also clears the state to IDLE, the indices i/j/k, the accumulator, and the a_reg/b_reg capture registers. Reset takes effect immediately, including mid-run: no further writes are issued and partially computed results are discarded.
- Element layout is row-major:
  - A(i,k) at DM1 word A_BASE+i*N+k.
  - B(k,j) at DM2 word B_BASE+k*N+j.
  - C(i,j) at DM3 word C_BASE+i*N+j.
  - Word arithmetic is truncated to 12 bits, so addresses wrap modulo 4096.
- Only mem_q[7:0] is used as an element value; mem_q[31:8] is ignored.
- The accumulator is 32-bit unsigned. Maximum sum is 64*255*255 = 4,161,600, so it cannot overflow.
- State machine:
  - IDLE: outputs 0. If start=1, clear i, j, k and the accumulator, then go to RD_A.
  - RD_A: mem_address={4'h0, A word}, mem_write_en=0. Next state RD_B.
  - RD_B: mem_address={4'h1, B word}. Capture a_reg<=mem_q[7:0]. Next state MAC.
  - MAC: mem_address=0. Capture b from mem_q[7:0] and perform acc<=acc+a_reg*mem_q[7:0] (16-bit product, zero-extended).
    - If k==N-1: k<=0, go to WR.
    - Else: k<=k+1, go to RD_A.
  - WR: mem_address={4'h2, C word}, mem_data=acc, mem_write_en=1 for exactly this one cycle. Then acc<=0.
    - If j==N-1: j<=0 and i<=i+1; else j<=j+1.
    - If i==N-1 and j==N-1: go to DONE; else go to RD_A.
  - DONE: done=1, busy=1. Next state IDLE.
- mem_data is 0 in every state except WR. mem_write_en is 1 only in WR.
- start is ignored while busy, including in the DONE state.
- If start is still high in the IDLE cycle after DONE, a new run begins; back-to-back runs need no gap beyond that one IDLE cycle.
- Latency: with start sampled at edge 0, RD_A begins at edge 0. The run spends N*N*(3N+1) cycles in RD_A/RD_B/MAC/WR, then one DONE cycle. For N=2, done is high in cycle 29 (cycles numbered from 1).
- Outputs are registered or decoded from state only; there is no combinational path from mem_q or start to any output.

Test Plan:
- Reset behaviour: assert reset with start=1 -> all outputs 0 and state IDLE. Release reset with start=0 -> no bus activity.
- Identity multiply: N=2, A=[[1,2],[3,4]], B=identity -> four writes, to 0x2000=1, 0x2001=2, 0x2002=3, 0x2003=4. Each write_en pulse lasts 1 cycle; done pulses in cycle 29; busy then falls.
- Saturation values: N=2, all A and B elements 255 -> every C word equals 130050 (32'h0001FC02).
- Upper-lane masking: DM1 model returns 0xABCDEF00|elem and DM2 model returns {elem,elem,elem,elem} -> results are identical to the identity-multiply case.
- Start handling: pulse start mid-run -> ignored, no restart. Hold start high through DONE -> second run begins after one IDLE cycle with correct, freshly cleared accumulators.
- Reset mid-run: assert reset during the MAC of C(1,0) -> mem_write_en stays 0 and outputs drop immediately. A subsequent start yields the full correct C with no stale accumulator contribution.

Source files
------------

// File: rtl/matmul_sequencer_if.sv
// Purpose: control and memory-bus bundle between matmul_sequencer and its host/memory controller.
// Latency: wires only; mem_q is expected one cycle after mem_address is presented.
// Backpressure: none; the controller accepts one access every cycle.
//
// Signals: start (host -> seq), busy/done (seq -> host),
//          mem_address/mem_data/mem_write_en (seq -> controller), mem_q (controller -> seq).
interface matmul_sequencer_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_write_en;
  logic [31:0] mem_q;

  modport master (
    input  start, mem_q,
    output busy, done, mem_address, mem_data, mem_write_en
  );

  modport slave (
    output start, mem_q,
    input  busy, done, mem_address, mem_data, mem_write_en
  );
endinterface

// File: rtl/matmul_sequencer.sv
// Purpose: sequences an unsigned 8-bit NxN matrix multiply C = A x B over the shared memory bus.
// Latency: N*N*(3N+1) bus cycles after start, then a one-cycle done pulse.
// Backpressure: none; issues one access per cycle and ignores start until back in IDLE.
//
// Ports: clk, reset (async, active-high), bus (master modport):
//   start in; busy/done out; mem_address {page,word}, mem_data, mem_write_en out; mem_q in.
//   A lives in page 0, B in page 1, C in page 2; all matrices are row-major.
module matmul_sequencer #(
  parameter int          N      = 4,
  parameter logic [11:0] A_BASE = 12'h000,
  parameter logic [11:0] B_BASE = 12'h000,
  parameter logic [11:0] C_BASE = 12'h000
) (
  input  logic               clk,
  input  logic               reset,
  matmul_sequencer_if.master bus
);

  // Index i runs one past N-1 on the final write, so 7 bits cover N up to 64.
  localparam logic [6:0] LAST = 7'(N - 1);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, MAC, WR, DONE} state_t;

  state_t      state_q, state_d;
  logic [6:0]  i_q, i_d, j_q, j_d, k_q, k_d;
  logic [31:0] acc_q, acc_d;
  logic [7:0]  a_q, a_d;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] mem_address_q, mem_address_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        mem_write_en_q, mem_write_en_d;

  // Only the low byte of a read word carries an element.
  logic unused_q_hi;
  assign unused_q_hi = ^bus.mem_q[31:8];

  // Row-major word offset, wrapping modulo 4096.
  function automatic logic [11:0] word_of(input logic [11:0] base,
                                          input logic [6:0]  row,
                                          input logic [6:0]  col);
    return 12'(32'(base) + 32'(row) * 32'(N) + 32'(col));
  endfunction

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    a_d     = a_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          state_d = RD_A;
        end
      end
      RD_A: state_d = RD_B;
      RD_B: begin
        // A word addressed in RD_A is on mem_q now.
        a_d     = bus.mem_q[7:0];
        state_d = MAC;
      end
      MAC: begin
        // B word addressed in RD_B is on mem_q now.
        acc_d = acc_q + 32'(a_q) * 32'(bus.mem_q[7:0]);
        if (k_q == LAST) begin
          k_d     = '0;
          state_d = WR;
        end else begin
          k_d     = k_q + 7'd1;
          state_d = RD_A;
        end
      end
      WR: begin
        acc_d = '0;
        if (j_q == LAST) begin
          j_d = '0;
          i_d = i_q + 7'd1;
        end else begin
          j_d = j_q + 7'd1;
        end
        state_d = (i_q == LAST && j_q == LAST) ? DONE : RD_A;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are computed from the next state and indices and then
    // registered, so they line up with the state they describe while
    // keeping mem_q/start off any combinational path to the pins.
    busy_d         = (state_d != IDLE);
    done_d         = (state_d == DONE);
    mem_write_en_d = (state_d == WR);
    mem_data_d     = (state_d == WR) ? acc_d : 32'h0;
    case (state_d)
      RD_A:    mem_address_d = {4'h0, word_of(A_BASE, i_d, k_d)};
      RD_B:    mem_address_d = {4'h1, word_of(B_BASE, k_d, j_d)};
      WR:      mem_address_d = {4'h2, word_of(C_BASE, i_d, j_d)};
      default: mem_address_d = 16'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      i_q            <= '0;
      j_q            <= '0;
      k_q            <= '0;
      acc_q          <= '0;
      a_q            <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      mem_address_q  <= '0;
      mem_data_q     <= '0;
      mem_write_en_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      i_q            <= i_d;
      j_q            <= j_d;
      k_q            <= k_d;
      acc_q          <= acc_d;
      a_q            <= a_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      mem_address_q  <= mem_address_d;
      mem_data_q     <= mem_data_d;
      mem_write_en_q <= mem_write_en_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.mem_address  = mem_address_q;
  assign bus.mem_data     = mem_data_q;
  assign bus.mem_write_en = mem_write_en_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Purpose: self-checking bench for matmul_sequencer with a behavioural memory and matrix model.
// Latency: checks write timing against (3N+1) cycles per element plus one DONE cycle.
// Backpressure: memory answers every read one cycle after the address, no stalls.
module tb_matmul_sequencer;
  localparam int N   = 2;
  localparam int NN  = N * N;
  localparam int PER = 3 * N + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  matmul_sequencer_if bus();

  matmul_sequencer #(
    .N(N), .A_BASE(12'h000), .B_BASE(12'h000), .C_BASE(12'h000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [7:0]  a_el [NN];
  logic [7:0]  b_el [NN];
  logic [31:0] exp_c [NN];
  bit          upper;

  logic [15:0] wr_addr [$];
  logic [31:0] wr_data [$];
  int          wr_cyc [$];
  int          done_cyc [$];
  int          cyc, base, we_long, data_leak;
  int          n_cmp, n_fail;
  bit          prev_we;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: DM1 holds A, DM2 holds B; optional junk in the upper lanes.
  always @(posedge clk) begin
    logic [3:0] pg;
    int         w;
    pg = bus.mem_address[15:12];
    w  = int'(bus.mem_address[11:0]);
    if (pg == 4'h0 && w < NN)
      bus.mem_q <= upper ? (32'hABCDEF00 | {24'h0, a_el[w]}) : {24'h0, a_el[w]};
    else if (pg == 4'h1 && w < NN)
      bus.mem_q <= upper ? {4{b_el[w]}} : {24'h0, b_el[w]};
    else
      bus.mem_q <= $urandom;
  end

  // Bus monitor: logs writes and done pulses with their cycle stamps.
  always @(negedge clk) begin
    if (bus.mem_write_en) begin
      wr_addr.push_back(bus.mem_address);
      wr_data.push_back(bus.mem_data);
      wr_cyc.push_back(cyc);
      if (prev_we) we_long++;
    end
    if (!bus.mem_write_en && bus.mem_data !== 32'h0) data_leak++;
    if (bus.done) done_cyc.push_back(cyc);
    prev_we = bus.mem_write_en;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: C(i,j) = sum_k A(i,k)*B(k,j), using only the element bytes.
  function automatic void model();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < N; k++)
          s += int'(a_el[i*N+k]) * int'(b_el[k*N+j]);
        exp_c[i*N+j] = 32'(s);
      end
  endfunction

  task automatic launch(input bit hold);
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cyc.delete();
    base = cyc;
    bus.start = 1'b1;
    tick();
    check("busy_after_start", {31'h0, bus.busy}, 32'h1);
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (done_cyc.size() < target && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, done_cyc.size(), target);
  endtask

  // Run r occupies queue slots r*NN.. and starts coff cycles after base.
  task automatic check_run(input string tag, input int r, input int coff);
    check({tag, "_nwr"}, wr_addr.size(), (r + 1) * NN);
    if (wr_addr.size() >= (r + 1) * NN)
      for (int e = 0; e < NN; e++) begin
        check($sformatf("%s_addr%0d", tag, e), wr_addr[r*NN+e], {16'h0, 4'h2, 12'(e)});
        check($sformatf("%s_data%0d", tag, e), wr_data[r*NN+e], exp_c[e]);
        check($sformatf("%s_wcyc%0d", tag, e), wr_cyc[r*NN+e] - base, coff + (e + 1) * PER);
      end
    if (done_cyc.size() > r)
      check({tag, "_done_cyc"}, done_cyc[r] - base, coff + NN * PER + 1);
  endtask

  task automatic run_once(input string tag);
    model();
    launch(1'b0);
    wait_done(tag, 1, 400);
    check_run(tag, 0, 0);
    tick();
    check({tag, "_busy_fall"}, {31'h0, bus.busy}, 32'h0);
  endtask

  task automatic randomize_mats();
    for (int e = 0; e < NN; e++) begin
      a_el[e] = 8'($urandom);
      b_el[e] = 8'($urandom);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b1;
    upper = 1'b0;
    a_el = '{8'd1, 8'd2, 8'd3, 8'd4};
    b_el = '{8'd1, 8'd0, 8'd0, 8'd1};

    // Reset held with start high: everything quiet.
    repeat (3) tick();
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_done", {31'h0, bus.done}, 32'h0);
    check("rst_addr", {16'h0, bus.mem_address}, 32'h0);
    check("rst_data", bus.mem_data, 32'h0);
    check("rst_we", {31'h0, bus.mem_write_en}, 32'h0);

    // Release with start low: no bus activity.
    bus.start = 1'b0;
    reset = 1'b0;
    wr_addr.delete();
    repeat (10) tick();
    check("idle_nwr", wr_addr.size(), 0);
    check("idle_busy", {31'h0, bus.busy}, 32'h0);

    // Identity multiply.
    run_once("ident");

    // Saturated elements.
    for (int e = 0; e < NN; e++) begin
      a_el[e] = 8'hFF;
      b_el[e] = 8'hFF;
    end
    run_once("sat");
    if (wr_data.size() > 0) check("sat_const", wr_data[0], 32'h0001FC02);

    // Junk in the upper lanes must not change results.
    a_el = '{8'd1, 8'd2, 8'd3, 8'd4};
    b_el = '{8'd1, 8'd0, 8'd0, 8'd1};
    upper = 1'b1;
    run_once("upper");
    upper = 1'b0;

    // Random matrices.
    for (int t = 0; t < 3; t++) begin
      randomize_mats();
      run_once($sformatf("rand%0d", t));
    end

    // Start pulse mid-run is ignored.
    randomize_mats();
    model();
    launch(1'b0);
    repeat (8) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done("midstart", 1, 400);
    check_run("midstart", 0, 0);
    repeat (5) tick();
    check("midstart_no_rerun", wr_addr.size(), NN);
    check("midstart_idle", {31'h0, bus.busy}, 32'h0);

    // Start held through DONE: second run after exactly one IDLE cycle.
    randomize_mats();
    model();
    launch(1'b1);
    wait_done("hold1", 1, 400);
    check_run("hold1", 0, 0);
    randomize_mats();
    model();
    tick();
    check("hold_gap_idle", {31'h0, bus.busy}, 32'h0);
    tick();
    check("hold_rerun_busy", {31'h0, bus.busy}, 32'h1);
    bus.start = 1'b0;
    wait_done("hold2", 2, 400);
    check_run("hold2", 1, NN * PER + 2);
    tick();
    check("hold2_busy_fall", {31'h0, bus.busy}, 32'h0);

    // Reset during the first MAC of C(1,0) (cycle 2*PER+3).
    randomize_mats();
    model();
    launch(1'b0);
    repeat (2 * PER + 2) tick();
    check("prerst_mac_addr", {16'h0, bus.mem_address}, 32'h0);
    check("prerst_nwr", wr_addr.size(), 2);
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'h0, bus.busy}, 32'h0);
    check("midrst_addr", {16'h0, bus.mem_address}, 32'h0);
    check("midrst_data", bus.mem_data, 32'h0);
    check("midrst_we", {31'h0, bus.mem_write_en}, 32'h0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (10) tick();
    check("postrst_nwr", wr_addr.size(), 2);
    check("postrst_ndone", done_cyc.size(), 0);
    randomize_mats();
    run_once("after_rst");

    check("we_single_cycle", we_long, 0);
    check("data_zero_outside_wr", data_leak, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
